// File: rtl/trap_sequencer_pkg.sv
// Purpose: shared types and constants for the M-mode trap/return sequencer.
// Latency: n/a (types, constants, pure functions only).
// Backpressure: n/a.
package trap_sequencer_pkg;

  localparam int MXLEN = 32;

  // CSR address type and the machine-mode CSRs this block touches.
  typedef logic [11:0] csr_address_t;
  localparam csr_address_t CSR_MSTATUS = 12'h300;
  localparam csr_address_t CSR_MIE     = 12'h304;
  localparam csr_address_t CSR_MTVEC   = 12'h305;
  localparam csr_address_t CSR_MEPC    = 12'h341;
  localparam csr_address_t CSR_MCAUSE  = 12'h342;
  localparam csr_address_t CSR_MTVAL   = 12'h343;
  localparam csr_address_t CSR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    WRITE_ONLY = 2'd1
  } csr_command_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    REDIRECT
  } trap_state_t;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam logic [MXLEN-2:0] IRQ_MEI = (MXLEN-1)'(11);
  localparam logic [MXLEN-2:0] IRQ_MSI = (MXLEN-1)'(3);
  localparam logic [MXLEN-2:0] IRQ_MTI = (MXLEN-1)'(7);

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // mstatus on trap entry: stack MIE into MPIE, disable, previous mode = M.
  function automatic logic [MXLEN-1:0] trap_mstatus(input logic [MXLEN-1:0] m);
    logic [MXLEN-1:0] s;
    s = m;
    s[MSTATUS_MPIE_BIT]       = m[MSTATUS_MIE_BIT];
    s[MSTATUS_MIE_BIT]        = 1'b0;
    s[MSTATUS_MPP_LSB +: 2]   = 2'b11;
    return s;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP stays M (M-only core).
  function automatic logic [MXLEN-1:0] mret_mstatus(input logic [MXLEN-1:0] m);
    logic [MXLEN-1:0] s;
    s = m;
    s[MSTATUS_MIE_BIT]        = m[MSTATUS_MPIE_BIT];
    s[MSTATUS_MPIE_BIT]       = 1'b1;
    s[MSTATUS_MPP_LSB +: 2]   = 2'b11;
    return s;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Purpose: core/CSR-side bundle of the trap sequencer (requests, live CSRs, CSR write port, redirect).
// Latency: n/a (wiring only).
// Backpressure: requests are held by the core until trap_ack_o; busy_o stalls issue.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic                 exception_valid_i;
  logic [MXLEN-2:0]     exception_cause_i;
  logic [MXLEN-1:0]     exception_pc_i;
  logic [MXLEN-1:0]     exception_tval_i;
  logic                 mret_i;
  logic [MXLEN-1:0]     interrupt_pc_i;
  logic [MXLEN-1:0]     csr_mstatus_i;
  logic [MXLEN-1:0]     csr_mie_i;
  logic [MXLEN-1:0]     csr_mip_i;
  logic [MXLEN-1:0]     csr_mtvec_i;
  logic [MXLEN-1:0]     csr_mepc_i;
  csr_address_t         csr_address_o;
  csr_command_t         csr_command_o;
  logic [MXLEN-1:0]     csr_write_data_o;
  logic                 trap_ack_o;
  logic                 busy_o;
  logic                 redirect_valid_o;
  logic [MXLEN-1:0]     redirect_pc_o;

  // Core / CSR file side.
  modport master (
    output exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
           mret_i, interrupt_pc_i, csr_mstatus_i, csr_mie_i, csr_mip_i,
           csr_mtvec_i, csr_mepc_i,
    input  csr_address_o, csr_command_o, csr_write_data_o, trap_ack_o, busy_o,
           redirect_valid_o, redirect_pc_o
  );

  // Sequencer side.
  modport slave (
    input  exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
           mret_i, interrupt_pc_i, csr_mstatus_i, csr_mie_i, csr_mip_i,
           csr_mtvec_i, csr_mepc_i,
    output csr_address_o, csr_command_o, csr_write_data_o, trap_ack_o, busy_o,
           redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_sequencer_irq_priority_encoder.sv
// Purpose: picks the highest-priority enabled machine interrupt (MEI > MSI > MTI).
// Latency: combinational.
// Backpressure: none; interrupts stay pending in mip until serviced.
// Ports: i_pending = mie & mip, i_mie = mstatus.MIE; o_valid/o_cause = winner.
module trap_sequencer_irq_priority_encoder
  import trap_sequencer_pkg::*;
(
  input  logic [MXLEN-1:0] i_pending,
  input  logic             i_mie,
  output logic             o_valid,
  output logic [MXLEN-2:0] o_cause
);

  // Only the three machine interrupt lines matter; the rest are ignored.
  logic w_unused_pending;
  assign w_unused_pending = ^i_pending;

  always_comb begin
    o_valid = 1'b0;
    o_cause = '0;
    if (i_mie) begin
      if (i_pending[11]) begin
        o_valid = 1'b1;
        o_cause = IRQ_MEI;
      end else if (i_pending[3]) begin
        o_valid = 1'b1;
        o_cause = IRQ_MSI;
      end else if (i_pending[7]) begin
        o_valid = 1'b1;
        o_cause = IRQ_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Purpose: M-mode trap/MRET sequencer: writes mepc/mcause/mtval/mstatus then redirects the core.
// Latency: ack at cycle 0, redirect at cycle 5 (trap) or cycle 2 (MRET).
// Backpressure: requests held until trap_ack_o; busy_o stalls the core, inputs ignored while busy.
// Ports: clock_i, reset_ni (async active-low), bus (trap_sequencer_if.slave).
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [MXLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  trap_sequencer_if.slave        bus
);

  trap_state_t       r_state, w_next_state;
  logic [MXLEN-1:0]  r_pc, r_tval, r_mstatus, r_mepc, r_redirect_pc;
  logic [MXLEN-2:0]  r_cause;
  logic              r_irq, r_mret;

  logic              w_irq_valid;
  logic [MXLEN-2:0]  w_irq_cause;
  logic              w_ack;
  csr_command_t      w_csr_command;
  csr_address_t      w_csr_address;
  logic [MXLEN-1:0]  w_csr_data;
  logic [MXLEN-1:0]  w_base, w_trap_target, w_target;

  trap_sequencer_irq_priority_encoder u_irq_enc (
    .i_pending (bus.csr_mie_i & bus.csr_mip_i),
    .i_mie     (bus.csr_mstatus_i[MSTATUS_MIE_BIT]),
    .o_valid   (w_irq_valid),
    .o_cause   (w_irq_cause)
  );

  // mtvec is read live in the REDIRECT cycle; vectoring applies to interrupts only,
  // and reserved modes fall back to direct.
  assign w_base        = {bus.csr_mtvec_i[MXLEN-1:2], 2'b00};
  assign w_trap_target = (r_irq && bus.csr_mtvec_i[1:0] == MTVEC_MODE_VECTORED)
                         ? w_base + {r_cause[MXLEN-3:0], 2'b00} : w_base;
  assign w_target      = r_mret ? r_mepc : w_trap_target;

  always_comb begin
    w_next_state  = r_state;
    w_ack         = 1'b0;
    w_csr_command = NONE;
    w_csr_address = '0;
    w_csr_data    = '0;
    case (r_state)
      IDLE: begin
        // Gate with reset so the ack pulse is 0 throughout reset even if a request is held.
        if (reset_ni && (bus.exception_valid_i || bus.mret_i || w_irq_valid)) begin
          w_ack        = 1'b1;
          w_next_state = (!bus.exception_valid_i && bus.mret_i) ? WR_MSTATUS : WR_MEPC;
        end
      end
      WR_MEPC: begin
        w_csr_command = WRITE_ONLY;
        w_csr_address = CSR_MEPC;
        w_csr_data    = {r_pc[MXLEN-1:2], 2'b00};
        w_next_state  = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        w_csr_command = WRITE_ONLY;
        w_csr_address = CSR_MCAUSE;
        w_csr_data    = {r_irq, r_cause};
        w_next_state  = WR_MTVAL;
      end
      WR_MTVAL: begin
        w_csr_command = WRITE_ONLY;
        w_csr_address = CSR_MTVAL;
        w_csr_data    = r_tval;
        w_next_state  = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        w_csr_command = WRITE_ONLY;
        w_csr_address = CSR_MSTATUS;
        w_csr_data    = r_mret ? mret_mstatus(r_mstatus) : trap_mstatus(r_mstatus);
        w_next_state  = REDIRECT;
      end
      REDIRECT: w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_cause       <= '0;
      r_tval        <= '0;
      r_irq         <= 1'b0;
      r_mret        <= 1'b0;
      r_mstatus     <= '0;
      r_mepc        <= '0;
      r_redirect_pc <= RESET_VECTOR;
    end else begin
      r_state <= w_next_state;
      if (w_ack) begin
        r_mstatus <= bus.csr_mstatus_i;
        r_mepc    <= bus.csr_mepc_i;
        if (bus.exception_valid_i) begin
          r_pc    <= bus.exception_pc_i;
          r_cause <= bus.exception_cause_i;
          r_tval  <= bus.exception_tval_i;
          r_irq   <= 1'b0;
          r_mret  <= 1'b0;
        end else if (bus.mret_i) begin
          r_irq   <= 1'b0;
          r_mret  <= 1'b1;
        end else begin
          r_pc    <= bus.interrupt_pc_i;
          r_cause <= w_irq_cause;
          r_tval  <= '0;
          r_irq   <= 1'b1;
          r_mret  <= 1'b0;
        end
      end
      if (r_state == REDIRECT) r_redirect_pc <= w_target;
    end
  end

  assign bus.csr_command_o    = w_csr_command;
  assign bus.csr_address_o    = w_csr_address;
  assign bus.csr_write_data_o = w_csr_data;
  assign bus.trap_ack_o       = w_ack;
  assign bus.busy_o           = (r_state != IDLE);
  assign bus.redirect_valid_o = (r_state == REDIRECT);
  // The target is live during REDIRECT and held in r_redirect_pc afterwards.
  assign bus.redirect_pc_o    = (r_state == REDIRECT) ? w_target : r_redirect_pc;

endmodule

// File: tb/tb_trap_sequencer.sv
// Purpose: directed self-checking bench for trap_sequencer (traps, vectored IRQs, MRET, reset).
// Latency: checks exact cycle positions of ack, each CSR write and the redirect.
// Backpressure: drives requests until ack, then updates mstatus as the handler would.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  trap_sequencer_if bus ();

  trap_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.exception_valid_i = 1'b0;
    bus.exception_cause_i = '0;
    bus.exception_pc_i    = '0;
    bus.exception_tval_i  = '0;
    bus.mret_i            = 1'b0;
    bus.interrupt_pc_i    = '0;
    bus.csr_mstatus_i     = '0;
    bus.csr_mie_i         = '0;
    bus.csr_mip_i         = '0;
    bus.csr_mtvec_i       = '0;
    bus.csr_mepc_i        = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd"},   32'(bus.csr_command_o), 32'(NONE));
    check({tag, " addr"},  32'(bus.csr_address_o), 32'h0);
    check({tag, " wdata"}, bus.csr_write_data_o, 32'h0);
    check({tag, " ack"},   32'(bus.trap_ack_o), 32'h0);
    check({tag, " busy"},  32'(bus.busy_o), 32'h0);
    check({tag, " rv"},    32'(bus.redirect_valid_o), 32'h0);
    check({tag, " rpc"},   bus.redirect_pc_o, 32'h0000_0000);
  endtask

  task automatic expect_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    check({tag, " cmd"},  32'(bus.csr_command_o), 32'(WRITE_ONLY));
    check({tag, " addr"}, 32'(bus.csr_address_o), 32'(addr));
    check({tag, " data"}, bus.csr_write_data_o, data);
    check({tag, " busy"}, 32'(bus.busy_o), 32'h1);
    check({tag, " rv"},   32'(bus.redirect_valid_o), 32'h0);
  endtask

  // Request already driven in the current cycle (cycle 0).
  task automatic run_trap(input string tag, input logic [31:0] mepc, input logic [31:0] mcause,
                          input logic [31:0] mtval, input logic [31:0] mstatus,
                          input logic [31:0] target);
    @(negedge clk);
    check({tag, " ack@0"},  32'(bus.trap_ack_o), 32'h1);
    check({tag, " busy@0"}, 32'(bus.busy_o), 32'h0);
    check({tag, " rv@0"},   32'(bus.redirect_valid_o), 32'h0);
    @(posedge clk); #1;
    bus.exception_valid_i = 1'b0;
    bus.csr_mstatus_i     = mstatus;   // handler's view after the write
    @(negedge clk);
    expect_write({tag, " mepc"}, CSR_MEPC, mepc);
    check({tag, " ack@1"}, 32'(bus.trap_ack_o), 32'h0);
    @(negedge clk);
    expect_write({tag, " mcause"}, CSR_MCAUSE, mcause);
    @(negedge clk);
    expect_write({tag, " mtval"}, CSR_MTVAL, mtval);
    @(negedge clk);
    expect_write({tag, " mstatus"}, CSR_MSTATUS, mstatus);
    @(negedge clk);
    check({tag, " rv@5"},   32'(bus.redirect_valid_o), 32'h1);
    check({tag, " rpc@5"},  bus.redirect_pc_o, target);
    check({tag, " cmd@5"},  32'(bus.csr_command_o), 32'(NONE));
    check({tag, " busy@5"}, 32'(bus.busy_o), 32'h1);
  endtask

  task automatic run_mret(input string tag, input logic [31:0] mstatus, input logic [31:0] target);
    @(negedge clk);
    check({tag, " ack@0"}, 32'(bus.trap_ack_o), 32'h1);
    @(posedge clk); #1;
    bus.mret_i        = 1'b0;
    bus.csr_mstatus_i = mstatus;
    @(negedge clk);
    expect_write({tag, " mstatus"}, CSR_MSTATUS, mstatus);
    @(negedge clk);
    check({tag, " rv@2"},  32'(bus.redirect_valid_o), 32'h1);
    check({tag, " rpc@2"}, bus.redirect_pc_o, target);
  endtask

  task automatic idle_check(input string tag, input logic [31:0] hold_pc);
    @(negedge clk);
    check({tag, " idle rv"},   32'(bus.redirect_valid_o), 32'h0);
    check({tag, " idle busy"}, 32'(bus.busy_o), 32'h0);
    check({tag, " idle ack"},  32'(bus.trap_ack_o), 32'h0);
    check({tag, " idle rpc"},  bus.redirect_pc_o, hold_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal instruction, direct mtvec.
    @(posedge clk); #1;
    bus.csr_mstatus_i     = 32'h8;
    bus.csr_mtvec_i       = 32'h0000_0200;
    bus.exception_cause_i = 31'd2;
    bus.exception_pc_i    = 32'h0000_0104;
    bus.exception_tval_i  = 32'h0000_0013;
    bus.exception_valid_i = 1'b1;
    run_trap("illegal", 32'h104, 32'h2, 32'h13, 32'h1880, 32'h200);
    idle_check("illegal", 32'h200);

    // Vectored MTI; tval input must not leak into mtval.
    @(posedge clk); #1;
    bus.csr_mstatus_i    = 32'h8;
    bus.csr_mtvec_i      = 32'h0000_0301;
    bus.csr_mie_i        = 32'h80;
    bus.csr_mip_i        = 32'h80;
    bus.interrupt_pc_i   = 32'h0000_0400;
    bus.exception_tval_i = 32'h0000_1234;
    run_trap("mti_vec", 32'h400, 32'h8000_0007, 32'h0, 32'h1880, 32'h31C);
    idle_check("mti_vec", 32'h31C);

    // Masked interrupts, then enable: MEI wins over MSI/MTI.
    @(posedge clk); #1;
    bus.csr_mstatus_i  = 32'h0;
    bus.csr_mie_i      = 32'h888;
    bus.csr_mip_i      = 32'h888;
    bus.interrupt_pc_i = 32'h0000_0500;
    bus.csr_mtvec_i    = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("masked ack",  32'(bus.trap_ack_o), 32'h0);
      check("masked busy", 32'(bus.busy_o), 32'h0);
    end
    @(posedge clk); #1;
    bus.csr_mstatus_i = 32'h8;
    run_trap("mei", 32'h500, 32'h8000_000B, 32'h0, 32'h1880, 32'h200);
    idle_check("mei", 32'h200);

    // MRET.
    @(posedge clk); #1;
    bus.csr_mie_i     = 32'h0;
    bus.csr_mip_i     = 32'h0;
    bus.csr_mstatus_i = 32'h1880;
    bus.csr_mepc_i    = 32'h0000_0108;
    bus.mret_i        = 1'b1;
    run_mret("mret", 32'h1888, 32'h108);
    idle_check("mret", 32'h108);

    // Exception beats a pending MTI; MTI follows once MRET re-enables MIE.
    @(posedge clk); #1;
    bus.csr_mstatus_i     = 32'h8;
    bus.csr_mie_i         = 32'h80;
    bus.csr_mip_i         = 32'h80;
    bus.csr_mtvec_i       = 32'h0000_0301;
    bus.interrupt_pc_i    = 32'h0000_0600;
    bus.exception_cause_i = 31'd11;
    bus.exception_pc_i    = 32'h0000_0600;
    bus.exception_tval_i  = 32'h0;
    bus.exception_valid_i = 1'b1;
    run_trap("exc_vs_mti", 32'h600, 32'hB, 32'h0, 32'h1880, 32'h300);
    idle_check("exc_vs_mti", 32'h300);
    @(posedge clk); #1;
    bus.csr_mepc_i       = 32'h0000_0604;
    bus.interrupt_pc_i   = 32'h0000_0604;
    bus.exception_tval_i = 32'hDEAD_BEEF;
    bus.mret_i           = 1'b1;
    run_mret("mret2", 32'h1888, 32'h604);
    run_trap("mti_after_mret", 32'h604, 32'h8000_0007, 32'h0, 32'h1880, 32'h31C);
    idle_check("mti_after_mret", 32'h31C);

    // Reset during WR_MCAUSE, then a clean full sequence.
    @(posedge clk); #1;
    bus.csr_mie_i         = 32'h0;
    bus.csr_mip_i         = 32'h0;
    bus.csr_mstatus_i     = 32'h8;
    bus.csr_mtvec_i       = 32'h0000_0200;
    bus.exception_cause_i = 31'd5;
    bus.exception_pc_i    = 32'h0000_0700;
    bus.exception_tval_i  = 32'h0;
    bus.exception_valid_i = 1'b1;
    @(negedge clk);
    check("rst_seq ack", 32'(bus.trap_ack_o), 32'h1);
    @(posedge clk); #1;
    bus.exception_valid_i = 1'b0;
    @(negedge clk);
    expect_write("rst_seq mepc", CSR_MEPC, 32'h700);
    @(negedge clk);
    expect_write("rst_seq mcause", CSR_MCAUSE, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.exception_cause_i = 31'd1;
    bus.exception_pc_i    = 32'h0000_0800;
    bus.exception_tval_i  = 32'h0000_0804;
    bus.exception_valid_i = 1'b1;
    run_trap("post_reset", 32'h800, 32'h1, 32'h804, 32'h1880, 32'h200);
    idle_check("post_reset", 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
